// File: rtl/pcie_pkt_dispatch_if.sv
// Bundle of every non-clock signal around the packet dispatcher: the two
// show-ahead buffer heads it pops from, the flit stream towards the DMA
// front-end, and the statistics counters. The dispatcher sits on the master
// side; whatever models the buffers and the DMA sits on the slave side.
interface pcie_pkt_dispatch_if #(
    parameter int FLOW_IDX_WIDTH = 13,
    parameter int APP_IDX_WIDTH  = 10,
    parameter int SIZE_WIDTH     = 16,
    parameter int CNT_WIDTH      = 32
) ();
    // Descriptor buffer head
    logic [APP_IDX_WIDTH-1:0]  desc_rd_dsc_queue_id;
    logic [FLOW_IDX_WIDTH-1:0] desc_rd_pkt_queue_id;
    logic [SIZE_WIDTH-1:0]     desc_rd_size;
    logic                      desc_empty;
    logic                      desc_rd_en;

    // Packet buffer head
    logic [511:0]              pkt_rd_data;
    logic                      pkt_rd_sop;
    logic                      pkt_rd_eop;
    logic                      pkt_empty;
    logic                      pkt_rd_en;

    // Flit stream to the DMA front-end
    logic [511:0]              out_data;
    logic                      out_sop;
    logic                      out_eop;
    logic [FLOW_IDX_WIDTH-1:0] out_pkt_queue_id;
    logic [APP_IDX_WIDTH-1:0]  out_dsc_queue_id;
    logic [SIZE_WIDTH-1:0]     out_size;
    logic                      out_valid;
    logic                      out_ready;

    // Statistics
    logic [CNT_WIDTH-1:0]      pkt_count;
    logic [CNT_WIDTH-1:0]      err_count;

    modport master (
        input  desc_rd_dsc_queue_id, desc_rd_pkt_queue_id, desc_rd_size, desc_empty,
        output desc_rd_en,
        input  pkt_rd_data, pkt_rd_sop, pkt_rd_eop, pkt_empty,
        output pkt_rd_en,
        output out_data, out_sop, out_eop, out_pkt_queue_id, out_dsc_queue_id, out_size,
        output out_valid,
        input  out_ready,
        output pkt_count, err_count
    );

    modport slave (
        output desc_rd_dsc_queue_id, desc_rd_pkt_queue_id, desc_rd_size, desc_empty,
        input  desc_rd_en,
        output pkt_rd_data, pkt_rd_sop, pkt_rd_eop, pkt_empty,
        input  pkt_rd_en,
        input  out_data, out_sop, out_eop, out_pkt_queue_id, out_dsc_queue_id, out_size,
        input  out_valid,
        output out_ready,
        input  pkt_count, err_count
    );
endinterface

// File: rtl/pcie_pkt_dispatch.sv
// Packet dispatcher: pops one descriptor, then streams exactly that many
// flits from the packet buffer into a single output register towards the
// PCIe DMA front-end. Buffer framing (sop/eop) is checked against the
// descriptor; a short packet is cut at its eop, a long one is cut at the
// descriptor length and its tail is drained. Each faulty packet bumps
// err_count once.
module pcie_pkt_dispatch #(
    parameter int PDU_AWIDTH     = 12,
    parameter int FLOW_IDX_WIDTH = 13,
    parameter int APP_IDX_WIDTH  = 10,
    parameter int SIZE_WIDTH     = 16,
    parameter int CNT_WIDTH      = 32
) (
    input  logic               clk,
    input  logic               rst,
    pcie_pkt_dispatch_if.master bus
);

    // The buffer address width only sizes upstream occupancy views; nothing
    // in the datapath depends on it, but a zero width is never meaningful.
    if (PDU_AWIDTH < 1) begin : g_bad_pdu_awidth
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [FLOW_IDX_WIDTH-1:0] pqid_q, pqid_d;
    logic [APP_IDX_WIDTH-1:0]  dqid_q, dqid_d;
    logic [SIZE_WIDTH-1:0]     size_q, size_d;
    logic [SIZE_WIDTH-1:0]     rem_q, rem_d;
    logic                      first_q, first_d;
    logic                      err_seen_q, err_seen_d;

    logic                      out_valid_q, out_valid_d;
    logic [511:0]              out_data_q, out_data_d;
    logic                      out_sop_q, out_sop_d;
    logic                      out_eop_q, out_eop_d;
    logic [FLOW_IDX_WIDTH-1:0] out_pqid_q, out_pqid_d;
    logic [APP_IDX_WIDTH-1:0]  out_dqid_q, out_dqid_d;
    logic [SIZE_WIDTH-1:0]     out_size_q, out_size_d;

    logic [CNT_WIDTH-1:0]      pkt_cnt_q, pkt_cnt_d;
    logic [CNT_WIDTH-1:0]      err_cnt_q, err_cnt_d;

    logic adv;
    logic desc_pop;
    logic pkt_pop;
    logic last_flit;
    logic flit_err;

    // Output register may take a new flit when empty or being drained this cycle
    assign adv       = !out_valid_q || bus.out_ready;
    assign last_flit = (rem_q == SIZE_WIDTH'(1));
    assign flit_err  = (bus.pkt_rd_sop != first_q)
                     || (bus.pkt_rd_eop && !last_flit)
                     || (last_flit && !bus.pkt_rd_eop);

    // Pops are combinational so the show-ahead heads advance on the same edge
    // the entry is consumed; reset blocks them at once.
    assign desc_pop = !rst && (state_q == IDLE) && !bus.desc_empty;
    assign pkt_pop  = !rst && !bus.pkt_empty
                    && (((state_q == STREAM) && adv) || (state_q == DRAIN));

    // Next-state, output-register and counter logic
    always_comb begin
        // NOTE: every target gets a default first so no path leaves a value
        // unassigned; otherwise synthesis infers a latch.
        state_d     = state_q;
        pqid_d      = pqid_q;
        dqid_d      = dqid_q;
        size_d      = size_q;
        rem_d       = rem_q;
        first_d     = first_q;
        err_seen_d  = err_seen_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_pqid_d  = out_pqid_q;
        out_dqid_d  = out_dqid_q;
        out_size_d  = out_size_q;
        pkt_cnt_d   = pkt_cnt_q;
        err_cnt_d   = err_cnt_q;

        if (out_valid_q && bus.out_ready && out_eop_q) begin
            pkt_cnt_d = pkt_cnt_q + 1'b1;
        end

        // A flit handed to the DMA empties the register unless refilled below
        if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (desc_pop) begin
                    if (bus.desc_rd_size == '0) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end else begin
                        pqid_d     = bus.desc_rd_pkt_queue_id;
                        dqid_d     = bus.desc_rd_dsc_queue_id;
                        size_d     = bus.desc_rd_size;
                        rem_d      = bus.desc_rd_size;
                        first_d    = 1'b1;
                        err_seen_d = 1'b0;
                        state_d    = STREAM;
                    end
                end
            end

            STREAM: begin
                if (pkt_pop) begin
                    out_valid_d = 1'b1;
                    out_data_d  = bus.pkt_rd_data;
                    out_sop_d   = first_q;
                    out_eop_d   = last_flit || bus.pkt_rd_eop;
                    out_pqid_d  = pqid_q;
                    out_dqid_d  = dqid_q;
                    out_size_d  = size_q;
                    first_d     = 1'b0;
                    rem_d       = rem_q - 1'b1;
                    if (flit_err && !err_seen_q) begin
                        err_cnt_d  = err_cnt_q + 1'b1;
                        err_seen_d = 1'b1;
                    end
                    if (bus.pkt_rd_eop) begin
                        state_d = IDLE;
                    end else if (last_flit) begin
                        state_d = DRAIN;
                    end
                end
            end

            DRAIN: begin
                if (pkt_pop && bus.pkt_rd_eop) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pqid_q      <= '0;
            dqid_q      <= '0;
            size_q      <= '0;
            rem_q       <= '0;
            first_q     <= 1'b0;
            err_seen_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_pqid_q  <= '0;
            out_dqid_q  <= '0;
            out_size_q  <= '0;
            pkt_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value, independent of statement order.
            state_q     <= state_d;
            pqid_q      <= pqid_d;
            dqid_q      <= dqid_d;
            size_q      <= size_d;
            rem_q       <= rem_d;
            first_q     <= first_d;
            err_seen_q  <= err_seen_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_pqid_q  <= out_pqid_d;
            out_dqid_q  <= out_dqid_d;
            out_size_q  <= out_size_d;
            pkt_cnt_q   <= pkt_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.desc_rd_en       = desc_pop;
    assign bus.pkt_rd_en        = pkt_pop;
    assign bus.out_valid        = out_valid_q;
    assign bus.out_data         = out_data_q;
    assign bus.out_sop          = out_sop_q;
    assign bus.out_eop          = out_eop_q;
    assign bus.out_pkt_queue_id = out_pqid_q;
    assign bus.out_dsc_queue_id = out_dqid_q;
    assign bus.out_size         = out_size_q;
    assign bus.pkt_count        = pkt_cnt_q;
    assign bus.err_count        = err_cnt_q;

endmodule

// File: tb/tb_pcie_pkt_dispatch.sv
// Bench for pcie_pkt_dispatch: show-ahead buffer models fed from queues, a
// packet-level reference model of the expected flit stream and counters,
// directed scenarios followed by a randomized run.
module tb_pcie_pkt_dispatch;

    localparam int FW = 13;
    localparam int AW = 10;
    localparam int SW = 16;
    localparam int CW = 32;

    typedef struct {
        logic [511:0] data;
        bit           sop;
        bit           eop;
    } flit_t;

    typedef struct {
        logic [FW-1:0] pq;
        logic [AW-1:0] dq;
        logic [SW-1:0] len;
    } desc_t;

    typedef struct {
        logic [511:0] data;
        bit           sop;
        bit           eop;
        logic [FW-1:0] pq;
        logic [AW-1:0] dq;
        logic [SW-1:0] len;
    } out_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pcie_pkt_dispatch_if #(
        .FLOW_IDX_WIDTH(FW), .APP_IDX_WIDTH(AW), .SIZE_WIDTH(SW), .CNT_WIDTH(CW)
    ) bus ();

    pcie_pkt_dispatch #(
        .PDU_AWIDTH(12), .FLOW_IDX_WIDTH(FW), .APP_IDX_WIDTH(AW),
        .SIZE_WIDTH(SW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    desc_t scen_desc[$];
    flit_t scen_flit[$];
    desc_t desc_feed[$];
    flit_t pkt_feed[$];
    out_t  exp_q[$];
    int    acc_cyc[$];

    int    n_pass  = 0;
    int    n_fail  = 0;
    int    n_total = 0;
    int    exp_pkt = 0;
    int    exp_err = 0;
    int    cyc     = 0;
    int    ready_mode = 0;
    bit    stall_en   = 1'b0;
    bit    prev_stall = 1'b0;
    out_t  prev_out;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_data(string tag, logic [511:0] obs, logic [511:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rnd_data();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic add_desc(int pq, int dq, int len);
        desc_t d;
        d.pq  = FW'(pq);
        d.dq  = AW'(dq);
        d.len = SW'(len);
        scen_desc.push_back(d);
    endtask

    // One buffer packet of n flits; bad_sop drops the sop marker on flit 0
    task automatic add_pkt(int n, bit bad_sop);
        flit_t f;
        for (int i = 0; i < n; i++) begin
            f.data = rnd_data();
            f.sop  = (i == 0) && !bad_sop;
            f.eop  = (i == n - 1);
            scen_flit.push_back(f);
        end
    endtask

    // Packet-level reference: walk descriptors against the flat flit stream
    task automatic run_model();
        int p = 0;
        for (int k = 0; k < scen_desc.size(); k++) begin
            int rem;
            bit first;
            bit bad;
            bit done;
            rem   = int'(scen_desc[k].len);
            first = 1'b1;
            bad   = 1'b0;
            done  = 1'b0;
            if (rem == 0) begin
                exp_err++;
            end else begin
                while (!done && p < scen_flit.size()) begin
                    flit_t f;
                    out_t  o;
                    f = scen_flit[p];
                    p++;
                    o.data = f.data;
                    o.sop  = first;
                    o.eop  = (rem == 1) || f.eop;
                    o.pq   = scen_desc[k].pq;
                    o.dq   = scen_desc[k].dq;
                    o.len  = scen_desc[k].len;
                    if ((f.sop != first) || (f.eop && rem > 1) || (rem == 1 && !f.eop)) bad = 1'b1;
                    exp_q.push_back(o);
                    if (o.eop) begin
                        exp_pkt++;
                        done = 1'b1;
                        if (!f.eop) begin
                            while (p < scen_flit.size() && !scen_flit[p].eop) p++;
                            p++;
                        end
                    end
                    first = 1'b0;
                    rem--;
                end
                if (bad) exp_err++;
            end
        end
    endtask

    // One clock: drive heads at the falling edge, sample, then apply pops
    task automatic step();
        logic acc;
        bit   d_empty;
        bit   p_empty;
        bit   dpop;
        bit   ppop;
        out_t o;

        d_empty = (desc_feed.size() == 0) || (stall_en && $urandom_range(0, 3) == 0);
        p_empty = (pkt_feed.size() == 0) || (stall_en && $urandom_range(0, 3) == 0);
        bus.desc_empty = d_empty;
        bus.pkt_empty  = p_empty;
        if (desc_feed.size() > 0) begin
            bus.desc_rd_pkt_queue_id = desc_feed[0].pq;
            bus.desc_rd_dsc_queue_id = desc_feed[0].dq;
            bus.desc_rd_size         = desc_feed[0].len;
        end else begin
            bus.desc_rd_pkt_queue_id = '0;
            bus.desc_rd_dsc_queue_id = '0;
            bus.desc_rd_size         = '0;
        end
        if (pkt_feed.size() > 0) begin
            bus.pkt_rd_data = pkt_feed[0].data;
            bus.pkt_rd_sop  = pkt_feed[0].sop;
            bus.pkt_rd_eop  = pkt_feed[0].eop;
        end else begin
            bus.pkt_rd_data = '0;
            bus.pkt_rd_sop  = 1'b0;
            bus.pkt_rd_eop  = 1'b0;
        end
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = (cyc % 3 == 0);
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
        #1;

        if (prev_stall) begin
            check("hold_valid", 64'(bus.out_valid), 64'(1));
            check_data("hold_data", bus.out_data, prev_out.data);
            check("hold_meta",
                  64'({bus.out_sop, bus.out_eop, bus.out_pkt_queue_id, bus.out_dsc_queue_id, bus.out_size}),
                  64'({prev_out.sop, prev_out.eop, prev_out.pq, prev_out.dq, prev_out.len}));
        end
        if (bus.desc_rd_en) check("desc_pop_on_empty", 64'(d_empty), 64'(0));
        if (bus.pkt_rd_en)  check("pkt_pop_on_empty", 64'(p_empty), 64'(0));

        acc = bus.out_valid && bus.out_ready;
        if (exp_q.size() == 0) begin
            check("spurious_flit", 64'(acc), 64'(0));
        end else if (acc) begin
            o = exp_q.pop_front();
            check_data("flit_data", bus.out_data, o.data);
            check("flit_meta",
                  64'({bus.out_sop, bus.out_eop, bus.out_pkt_queue_id, bus.out_dsc_queue_id, bus.out_size}),
                  64'({o.sop, o.eop, o.pq, o.dq, o.len}));
        end
        if (acc) acc_cyc.push_back(cyc);

        prev_stall    = bus.out_valid && !bus.out_ready;
        prev_out.data = bus.out_data;
        prev_out.sop  = bus.out_sop;
        prev_out.eop  = bus.out_eop;
        prev_out.pq   = bus.out_pkt_queue_id;
        prev_out.dq   = bus.out_dsc_queue_id;
        prev_out.len  = bus.out_size;
        dpop = bus.desc_rd_en && !d_empty;
        ppop = bus.pkt_rd_en && !p_empty;

        @(posedge clk);
        if (dpop) void'(desc_feed.pop_front());
        if (ppop) void'(pkt_feed.pop_front());
        cyc++;
        @(negedge clk);
    endtask

    task automatic load_scenario();
        run_model();
        foreach (scen_desc[i]) desc_feed.push_back(scen_desc[i]);
        foreach (scen_flit[i]) pkt_feed.push_back(scen_flit[i]);
        scen_desc.delete();
        scen_flit.delete();
        acc_cyc.delete();
    endtask

    task automatic run_scenario(string name, int rmode, bit stall);
        int budget = 0;
        ready_mode = rmode;
        stall_en   = stall;
        load_scenario();
        while (!(exp_q.size() == 0 && desc_feed.size() == 0 && pkt_feed.size() == 0
                 && bus.out_valid == 1'b0) && budget < 3000) begin
            step();
            budget++;
        end
        check({name, "_done_in_budget"}, 64'(budget < 3000), 64'(1));
        check({name, "_pkt_count"}, 64'(bus.pkt_count), 64'(exp_pkt));
        check({name, "_err_count"}, 64'(bus.err_count), 64'(exp_err));
    endtask

    initial begin
        int budget;

        // Reset with both heads valid: nothing may pop, all outputs zero
        rst = 1'b1;
        bus.desc_empty = 1'b0;
        bus.pkt_empty  = 1'b0;
        bus.desc_rd_size = 16'd3;
        bus.desc_rd_pkt_queue_id = '0;
        bus.desc_rd_dsc_queue_id = '0;
        bus.pkt_rd_data = '1;
        bus.pkt_rd_sop  = 1'b1;
        bus.pkt_rd_eop  = 1'b0;
        bus.out_ready   = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_desc_rd_en", 64'(bus.desc_rd_en), 64'(0));
        check("rst_pkt_rd_en", 64'(bus.pkt_rd_en), 64'(0));
        check_data("rst_out_data", bus.out_data, '0);
        check("rst_out_meta",
              64'({bus.out_sop, bus.out_eop, bus.out_pkt_queue_id, bus.out_dsc_queue_id, bus.out_size}),
              64'(0));
        check("rst_pkt_count", 64'(bus.pkt_count), 64'(0));
        check("rst_err_count", 64'(bus.err_count), 64'(0));
        bus.desc_empty = 1'b1;
        bus.pkt_empty  = 1'b1;
        rst = 1'b0;
        @(negedge clk);

        // Single 1-flit packet, queue IDs 5/3
        add_desc(5, 3, 1);
        add_pkt(1, 1'b0);
        run_scenario("single", 0, 1'b0);
        check("single_pkt_total", 64'(bus.pkt_count), 64'(1));
        check("single_err_total", 64'(bus.err_count), 64'(0));

        // Back-to-back 3 and 2 flit packets: one bubble between them
        add_desc(100, 20, 3);
        add_pkt(3, 1'b0);
        add_desc(101, 21, 2);
        add_pkt(2, 1'b0);
        run_scenario("b2b", 0, 1'b0);
        check("b2b_flits", 64'(acc_cyc.size()), 64'(5));
        if (acc_cyc.size() == 5) begin
            check("b2b_gap_1_2", 64'(acc_cyc[1] - acc_cyc[0]), 64'(1));
            check("b2b_gap_2_3", 64'(acc_cyc[2] - acc_cyc[1]), 64'(1));
            check("b2b_gap_3_4", 64'(acc_cyc[3] - acc_cyc[2]), 64'(2));
            check("b2b_gap_4_5", 64'(acc_cyc[4] - acc_cyc[3]), 64'(1));
        end

        // 4-flit packet under a 1,0,0 ready pattern
        add_desc(7, 9, 4);
        add_pkt(4, 1'b0);
        run_scenario("backpressure", 1, 1'b0);
        check("backpressure_flits", 64'(acc_cyc.size()), 64'(4));

        // Descriptor shorter than buffer packet, then a good packet
        add_desc(11, 12, 2);
        add_pkt(4, 1'b0);
        add_desc(13, 14, 3);
        add_pkt(3, 1'b0);
        run_scenario("overrun", 0, 1'b0);

        // Descriptor longer than buffer packet, then a good packet
        add_desc(15, 16, 4);
        add_pkt(2, 1'b0);
        add_desc(17, 18, 2);
        add_pkt(2, 1'b0);
        run_scenario("truncate", 0, 1'b0);

        // Zero-size descriptor and a missing sop marker
        add_desc(19, 20, 0);
        add_desc(21, 22, 2);
        add_pkt(2, 1'b1);
        run_scenario("zero_and_sop", 0, 1'b0);

        // Randomized mix with buffer stalls and random ready
        for (int i = 0; i < 40; i++) begin
            int n;
            int r;
            n = $urandom_range(1, 6);
            r = $urandom_range(0, 9);
            if (r == 0) begin
                add_desc($urandom_range(0, 8191), $urandom_range(0, 1023), 0);
            end else begin
                add_desc($urandom_range(0, 8191), $urandom_range(0, 1023),
                         (r <= 6) ? n : $urandom_range(1, 7));
                add_pkt(n, $urandom_range(0, 7) == 0);
            end
        end
        run_scenario("random", 2, 1'b1);

        // Reset in the middle of a 5-flit packet
        add_desc(30, 31, 5);
        add_pkt(5, 1'b0);
        ready_mode = 0;
        stall_en   = 1'b0;
        load_scenario();
        budget = 0;
        while (acc_cyc.size() < 1 && budget < 50) begin
            step();
            budget++;
        end
        check("midrst_reached_flit", 64'(acc_cyc.size()), 64'(1));
        rst = 1'b1;
        bus.desc_empty = 1'b0;
        bus.pkt_empty  = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        check("midrst_pkt_count", 64'(bus.pkt_count), 64'(0));
        check("midrst_err_count", 64'(bus.err_count), 64'(0));
        check("midrst_desc_rd_en", 64'(bus.desc_rd_en), 64'(0));
        check("midrst_pkt_rd_en", 64'(bus.pkt_rd_en), 64'(0));
        desc_feed.delete();
        pkt_feed.delete();
        exp_q.delete();
        exp_pkt    = 0;
        exp_err    = 0;
        prev_stall = 1'b0;
        repeat (2) @(negedge clk);
        bus.desc_empty = 1'b1;
        bus.pkt_empty  = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        add_desc(40, 41, 2);
        add_pkt(2, 1'b0);
        run_scenario("after_rst", 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pcie_pkt_dispatch.md
Name: pcie_pkt_dispatch

Overview:
Sits directly downstream of the packet/descriptor buffers filled by the PDU generator. It pops one packet descriptor, then streams exactly that many flits from the packet buffer to the PCIe DMA front-end. Each packet is tagged with its queue IDs and size. Flit framing is checked against the descriptor and recovered on mismatch.

Parameters:
PDU_AWIDTH, 12, address width of both buffers (sizes the occupancy ports only)
FLOW_IDX_WIDTH, 13, packet-queue ID width
APP_IDX_WIDTH, 10, descriptor-queue ID width
SIZE_WIDTH, 16, descriptor size field width (units: 64-byte flits)
CNT_WIDTH, 32, statistics counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
desc_rd_dsc_queue_id  in  APP_IDX_WIDTH  head descriptor, descriptor-queue ID
desc_rd_pkt_queue_id  in  FLOW_IDX_WIDTH  head descriptor, packet-queue ID
desc_rd_size  in  SIZE_WIDTH  head descriptor size in flits
desc_empty  in  1  descriptor buffer empty (show-ahead FIFO, head valid when 0)
desc_rd_en  out  1  pop descriptor head
pkt_rd_data  in  512  head flit payload
pkt_rd_sop  in  1  head flit start-of-packet
pkt_rd_eop  in  1  head flit end-of-packet
pkt_empty  in  1  packet buffer empty (show-ahead)
pkt_rd_en  out  1  pop packet head
out_data  out  512  flit to DMA
out_sop  out  1  first flit of packet
out_eop  out  1  last flit of packet
out_pkt_queue_id  out  FLOW_IDX_WIDTH  held for the whole packet
out_dsc_queue_id  out  APP_IDX_WIDTH  held for the whole packet
out_size  out  SIZE_WIDTH  descriptor size, held for the whole packet
out_valid  out  1  output flit valid
out_ready  in  1  DMA accepts flit when out_valid && out_ready
pkt_count  out  CNT_WIDTH  packets completed (eop accepted downstream)
err_count  out  CNT_WIDTH  framing errors detected

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs 0: out_valid, desc_rd_en, pkt_rd_en, out_*, pkt_count, err_count.
- Output stage is a single register. It may load when !out_valid || out_ready ("adv"). It holds all out_* stable while out_valid && !out_ready.
- desc_rd_en and pkt_rd_en are combinational pops and are asserted for at most one cycle per head entry.
- IDLE:
  - If !desc_empty: pop the descriptor, latch the queue IDs and size, set remaining=size, go to STREAM.
  - If desc_rd_size==0: pop the descriptor, err_count+1, stay in IDLE.
- STREAM:
  - pkt_rd_en = !pkt_empty && adv. On pop, load the output register: out_valid=1, data=pkt_rd_data.
  - out_sop=1 on the first flit of the descriptor, regardless of pkt_rd_sop.
  - out_eop=1 when remaining==1 or pkt_rd_eop.
  - remaining decrements per pop.
  - Errors (each counts err_count+1 once per packet):
    - pkt_rd_sop != first-flit.
    - pkt_rd_eop with remaining>1: packet is truncated, eop is emitted, go to IDLE.
    - remaining==1 with !pkt_rd_eop: eop is emitted, go to DRAIN.
  - Normal case (remaining==1 && pkt_rd_eop): go to IDLE.
- DRAIN:
  - Pop and discard flits (pkt_rd_en = !pkt_empty), output not loaded.
  - Return to IDLE after popping a flit with eop.
- Throughput: one flit per cycle inside a packet. One bubble cycle between packets (IDLE descriptor fetch). The IDLE->STREAM transition is not overlapped.
- If !adv and no new pop, the output register clears out_valid when out_ready is accepted.
- Counters: pkt_count increments when out_valid && out_ready && out_eop. Both counters wrap modulo 2^CNT_WIDTH.
- pkt_empty mid-packet: stall in STREAM, no bubble flit emitted, no timeout.
- Simultaneous error conditions on one flit count once.

Test Plan:
- Single 1-flit packet (size=1, sop=eop=1, qids 5/3), out_ready=1 -> one out flit, sop=eop=1, out_pkt_queue_id=5, out_dsc_queue_id=3, pkt_count=1, err_count=0.
- Back-to-back 3-flit and 2-flit packets, out_ready=1 -> 5 flits with exactly one IDLE bubble between packets; sop on flits 1 and 4, eop on flits 3 and 5; pkt_count=2.
- 4-flit packet with out_ready toggling 1,0,0,1,... -> data/sop/eop held stable while stalled, no flit lost or duplicated, 4 accepted flits in order.
- Descriptor size=2 but buffer packet is 4 flits (eop on 4th) -> 2 flits out, eop on 2nd, 2 flits drained, err_count=1; the next well-formed packet is delivered intact.
- Descriptor size=4 but packet eop on flit 2 -> 2 flits out with eop on 2nd, err_count=1, state returns to IDLE; the next descriptor is aligned.
- Assert rst mid-packet (flit 2 of 5) -> out_valid=0, counters=0, FIFO pops stop immediately; after release, the first descriptor processed starts with sop.
